io_bridge: RTL and testbench
============================

# io_bridge

Memory-mapped I/O bridge between the processor core's data-memory port and the board peripherals. It owns the 64×32 data RAM, the 18-bit LED register, the 32-bit seven-segment register, and a synchronized (optionally debounced) copy of the slide switches. It serves one start/done transaction at a time. Seg_reg feeds the eight hex_display decoders directly.

## Interface
- DEBOUNCE_CYCLES, 500000, stable-time threshold for switch changes (10 ms at 50 MHz)
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  request strobe from core, sampled only in IDLE
- wrt  in  1  1 = write, 0 = read; captured with start
- addr  in  32  word address; captured with start
- wdata  in  32  write data; captured with start
- rdata  out  32  read data, valid while done = 1
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse coincident with done for an unmapped address
- SW  in  18  raw board switches, asynchronous
- LED_reg  out  18  LED register
- Seg_reg  out  32  seven-segment register, nibble n drives HEXn

## Operation
- Address map, full 32-bit compare:
  - 0–63: RAM word addr[5:0].
  - 64: LED, read/write. Writes take wdata[17:0]. Reads return the value zero-extended.
  - 65: Seg, read/write, full 32 bits.
  - 66: switches, read-only. Reads return the stable switch value zero-extended. Writes are ignored and err is not raised.
  - Any other address: reads return 0, writes have no effect, err = 1 with done.
- FSM states IDLE, ACCESS, RESP.
  - IDLE: when start = 1, capture wrt/addr/wdata and go to ACCESS.
  - ACCESS: perform the write, or the synchronous RAM/register read; go to RESP.
  - RESP: done = 1, rdata driven, err if unmapped; go to IDLE.
- start is ignored in ACCESS and RESP. No queueing.
- If start is held high, a new transaction is accepted in IDLE on the cycle after RESP.
- Captured request values are used throughout. Input changes after capture have no effect.
- Switch path: 2-flop synchronizer, then the stable register.
- Reset values:
  - rdata, done, err, LED_reg, Seg_reg, stable switch value, debounce counter: all 0.
  - State: IDLE.
  - RAM contents are not reset.

## Timing
- start sampled at edge k. Write/read happens at edge k+1. done, rdata and err are valid in the cycle after edge k+2.
- Latency is 3 cycles. Maximum throughput is one transaction per 3 cycles.
- done never stays high for two consecutive cycles.
- rdata holds its last value after done falls.
- Reset asserted mid-transaction aborts it:
  - No done pulse.
  - A write scheduled for the same edge does not occur.
- A LED/Seg write becomes visible on its output the cycle after edge k+1.
- A switch change reaches the stable value no sooner than 2 cycles after the change (synchronizer latency only, when debounce is compiled out).

## Configuration
- SW_DEBOUNCE_EN defined:
  - One shared counter compares the synchronized switches against the stable value.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with them still differing, the stable value takes the synchronized value and the counter clears.
  - Any cycle where they are equal clears the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- SW_DEBOUNCE_EN undefined: the stable value equals the synchronizer output. No counter is instantiated.

## Structure
- io_bridge_pkg holds:
  - address constants RAM_LAST = 63, ADDR_LED = 64, ADDR_SEG = 65, ADDR_SW = 66;
  - the state enum {IDLE, ACCESS, RESP}.
- Sub-module sw_debounce contains the synchronizer and the conditional debounce logic. Its output is the 18-bit stable value.
- RAM is an inferred 64×32 array in io_bridge.

## Test plan
- Reset, then read addr 64 and 65 → rdata = 0 both times, done one cycle each, err = 0.
- Write 0xDEADBEEF to addr 5, then read addr 5 → rdata = 0xDEADBEEF exactly 3 cycles after start. Also write 0x3FFFF to 64 → LED_reg = 0x3FFFF.
- Write 0x12345678 to addr 65 → Seg_reg = 0x12345678. Pulse start during ACCESS → ignored, only one done.
- Read addr 100 → rdata = 0, err = 1 with done. Write addr 66 → no state change, err = 0.
- Set SW = 0x2A5A5 with debounce compiled out and read addr 66 → 0x0002A5A5.
- Debounce compiled in, DEBOUNCE_CYCLES = 8:
  - SW glitch held for 5 cycles → stable value unchanged.
  - SW change held for 20 cycles → addr 66 read returns the new value.
- Reset asserted in ACCESS of a write to addr 7 → no done; a subsequent read of addr 7 returns the prior value.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared address map, FSM state encoding and address decode for io_bridge.
package io_bridge_pkg;

  localparam logic [31:0] RAM_LAST = 32'd63;
  localparam logic [31:0] ADDR_LED = 32'd64;
  localparam logic [31:0] ADDR_SEG = 32'd65;
  localparam logic [31:0] ADDR_SW  = 32'd66;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  typedef enum logic [2:0] {T_RAM, T_LED, T_SEG, T_SW, T_NONE} target_e;

  // Full 32-bit compare: aliases of the peripheral addresses are unmapped.
  function automatic target_e decode_addr(input logic [31:0] a);
    if (a <= RAM_LAST)      return T_RAM;
    else if (a == ADDR_LED) return T_LED;
    else if (a == ADDR_SEG) return T_SEG;
    else if (a == ADDR_SW)  return T_SW;
    else                    return T_NONE;
  endfunction

endpackage

// File: rtl/io_bridge_sw_debounce.sv
// Switch synchronizer plus optional debounce (enable with macro SW_DEBOUNCE_EN).
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [17:0] sw_raw,
  output logic [17:0] sw_stable
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("sw_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [17:0] sync1_q, sync1_d;
  logic [17:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0]   stable_q, stable_d;

  // One counter for all switches: any disagreement must persist unbroken.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = sync2_q;
      else                  cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sw_stable = stable_q;
`else
  assign sw_stable = sync2_q;
`endif

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped bridge: 64x32 RAM, LED/seven-segment registers, switch input.
// Optional switch debounce via macro SW_DEBOUNCE_EN.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        wrt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  input  logic [17:0] SW,
  output logic [17:0] LED_reg,
  output logic [31:0] Seg_reg
);

  state_e      state_q, state_d;
  logic        wrt_q, wrt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [17:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic        ram_we;
  logic [17:0] sw_stable;
  target_e     tgt;

  logic [31:0] mem [64];

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .sw_raw    (SW),
    .sw_stable (sw_stable)
  );

  assign tgt = decode_addr(addr_q);

  always_comb begin
    state_d = state_q;
    wrt_d   = wrt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stage_d = stage_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    led_d   = led_q;
    seg_d   = seg_q;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          wrt_d   = wrt;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stage_d = '0;
        if (wrt_q) begin
          case (tgt)
            T_RAM:   ram_we = 1'b1;
            T_LED:   led_d  = wdata_q[17:0];
            T_SEG:   seg_d  = wdata_q;
            default: ;
          endcase
        end else begin
          case (tgt)
            T_RAM:   stage_d = mem[addr_q[5:0]];
            T_LED:   stage_d = {14'b0, led_q};
            T_SEG:   stage_d = seg_q;
            T_SW:    stage_d = {14'b0, sw_stable};
            default: stage_d = '0;
          endcase
        end
        state_d = RESP;
      end
      RESP: begin
        done_d  = 1'b1;
        err_d   = (tgt == T_NONE);
        rdata_d = stage_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      wrt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      stage_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      led_q   <= '0;
      seg_q   <= '0;
    end else begin
      state_q <= state_d;
      wrt_q   <= wrt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      stage_q <= stage_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      led_q   <= led_d;
      seg_q   <= seg_d;
    end
  end

  // RAM is not reset, but a reset on the write edge must still cancel the write.
  always_ff @(posedge CLOCK_50) begin
    if (ram_we && !reset) mem[addr_q[5:0]] <= wdata_q;
  end

  assign rdata   = rdata_q;
  assign done    = done_q;
  assign err     = err_q;
  assign LED_reg = led_q;
  assign Seg_reg = seg_q;

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: driver pushes expected responses, monitor checks on done.
module tb_io_bridge;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        wrt = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [17:0] SW = '0;
  logic [31:0] rdata;
  logic        done, err;
  logic [17:0] LED_reg;
  logic [31:0] Seg_reg;

  io_bridge #(.DEBOUNCE_CYCLES(8)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .wrt      (wrt),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .err      (err),
    .SW       (SW),
    .LED_reg  (LED_reg),
    .Seg_reg  (Seg_reg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

`ifdef SW_DEBOUNCE_EN
  localparam int SW_SETTLE = 30;
`else
  localparam int SW_SETTLE = 4;
`endif

  typedef struct {
    logic [31:0] rd;
    bit          chk_rd;
    bit          err;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] ram_m [64];
  logic [17:0] led_m = '0;
  logic [31:0] seg_m = '0;
  logic [17:0] sw_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the address map.
  task automatic push_exp(input bit w, input logic [31:0] a, input logic [31:0] d, input int at);
    exp_t e;
    e.rd = '0; e.chk_rd = !w; e.err = 1'b0; e.at = at;
    if (a < 64) begin
      if (w) ram_m[a[5:0]] = d; else e.rd = ram_m[a[5:0]];
    end else if (a == 64) begin
      if (w) led_m = d[17:0]; else e.rd = {14'b0, led_m};
    end else if (a == 65) begin
      if (w) seg_m = d; else e.rd = seg_m;
    end else if (a == 66) begin
      if (!w) e.rd = {14'b0, sw_m};
    end else begin
      e.err = 1'b1;
    end
    q.push_back(e);
  endtask

  // Returns on the negedge at which the response is visible.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLOCK_50);
    start = 1'b1; wrt = w; addr = a; wdata = d;
    push_exp(w, a, d, cyc + 3);
    @(negedge CLOCK_50);
    start = 1'b0; wrt = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
    repeat (2) @(negedge CLOCK_50);
  endtask

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", cyc, e.at);
        chk("err", {31'b0, err}, {31'b0, e.err});
        if (e.chk_rd) chk("rdata", rdata, e.rd);
        chk("led_reg", {14'b0, LED_reg}, {14'b0, led_m});
        chk("seg_reg", Seg_reg, seg_m);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, prior7;
    bit          w;

    repeat (3) @(negedge CLOCK_50);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_led", {14'b0, LED_reg}, 32'h0);
    chk("reset_seg", Seg_reg, 32'h0);
    reset = 1'b0;

    issue(0, 64, 0);
    issue(0, 65, 0);

    for (int i = 0; i < 64; i++) issue(1, i, $urandom);

    issue(1, 5, 32'hDEADBEEF);
    issue(0, 5, 0);
    @(negedge CLOCK_50);
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    chk("done_single", {31'b0, done}, 32'h0);
    issue(1, 64, 32'h0003FFFF);
    chk("led_all_ones", {14'b0, LED_reg}, 32'h0003FFFF);

    issue(1, 65, 32'h12345678);
    // Start stays high through ACCESS and RESP: only one transaction.
    @(negedge CLOCK_50);
    start = 1'b1; wrt = 1'b0; addr = 65;
    push_exp(0, 65, 0, cyc + 3);
    repeat (3) @(negedge CLOCK_50);
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    issue(0, 100, 0);
    issue(1, 66, 32'hFFFFFFFF);
    issue(0, 32'hFFFF0041, 0);
    issue(1, 32'h80000005, 32'h55AA55AA);
    issue(0, 5, 0);

    SW = 18'h2A5A5; sw_m = 18'h2A5A5;
    repeat (SW_SETTLE) @(negedge CLOCK_50);
    issue(0, 66, 0);

`ifdef SW_DEBOUNCE_EN
    SW = 18'h15A5A;
    repeat (5) @(negedge CLOCK_50);
    SW = 18'h2A5A5;
    repeat (20) @(negedge CLOCK_50);
    issue(0, 66, 0);
    SW = 18'h0F0F0; sw_m = 18'h0F0F0;
    repeat (20) @(negedge CLOCK_50);
    issue(0, 66, 0);
`endif

    // Start held high: accepted again in IDLE right after RESP.
    @(negedge CLOCK_50);
    start = 1'b1; wrt = 1'b0; addr = 64;
    push_exp(0, 64, 0, cyc + 3);
    push_exp(0, 64, 0, cyc + 6);
    repeat (6) @(negedge CLOCK_50);
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      case ($urandom_range(0, 6))
        0, 1, 2: a = $urandom_range(0, 63);
        3:       a = 64;
        4:       a = 65;
        5:       a = 66;
        default: a = $urandom | 32'h100;
      endcase
      issue(w, a, d);
    end

    // Reset lands on the write edge of addr 7: no done, RAM keeps the old word.
    prior7 = ram_m[7];
    @(negedge CLOCK_50);
    start = 1'b1; wrt = 1'b1; addr = 7; wdata = ~prior7;
    @(negedge CLOCK_50);
    start = 1'b0; reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_led", {14'b0, LED_reg}, 32'h0);
    reset = 1'b0; led_m = '0; seg_m = '0;
    issue(0, 7, 0);
    chk("abort_ram7", rdata, prior7);

    repeat (5) @(negedge CLOCK_50);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
